// File: rtl/tt_um_snpu.sv
// Single-neuron MAC unit: eight int8 weights, int8 bias, 24-bit accumulator, shift/activate/saturate on FIRE.
// Optional macro SNPU_RELU_EN selects ReLU activation (default: linear two's-complement saturation).

// Purpose: strobed command decoder driving a signed multiply-accumulate neuron.
// Latency: one cycle from the strobed command edge to uo_out / uio_out[7].
// Backpressure: none; a command is accepted on every cycle the strobe is high.
module tt_um_snpu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD_W   = 3'd1,
        OP_LOAD_B   = 3'd2,
        OP_CLEAR    = 3'd3,
        OP_MAC      = 3'd4,
        OP_FIRE     = 3'd5,
        OP_READ_ACC = 3'd6,
        OP_RSVD     = 3'd7
    } op_t;

    logic signed [7:0]  w [8];
    logic signed [7:0]  bias;
    logic signed [23:0] acc;
    logic [2:0]         ptr;
    logic [7:0]         out_q;
    logic               sat_q;

    op_t                op;
    logic               strobe;
    logic [2:0]         arg;
    logic signed [15:0] prod;
    logic signed [23:0] v;
    logic [7:0]         fire_out;
    logic               fire_sat;
    logic [7:0]         acc_byte;
    logic               unused_ok;

    assign op        = op_t'(uio_in[2:0]);
    assign strobe    = uio_in[3];
    assign arg       = uio_in[6:4];
    assign unused_ok = &{1'b0, ena, uio_in[7]};

    assign prod = $signed(ui_in) * w[ptr];
    assign v    = acc >>> arg;

    always_comb begin
        fire_out = v[7:0];
        fire_sat = 1'b0;
`ifdef SNPU_RELU_EN
        if (v < 24'sd0) begin
            fire_out = 8'h00;
        end else if (v > 24'sd255) begin
            fire_out = 8'hFF;
            fire_sat = 1'b1;
        end
`else
        if (v < -24'sd128) begin
            fire_out = 8'h80;
            fire_sat = 1'b1;
        end else if (v > 24'sd127) begin
            fire_out = 8'h7F;
            fire_sat = 1'b1;
        end
`endif
    end

    always_comb begin
        acc_byte = 8'h00;
        case (arg[1:0])
            2'd0:    acc_byte = acc[7:0];
            2'd1:    acc_byte = acc[15:8];
            2'd2:    acc_byte = acc[23:16];
            default: acc_byte = 8'h00;
        endcase
    end

    // rst_n is active-high despite its name; the harness expects this pin name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 8; i++) begin
                w[i] <= 8'sd0;
            end
            bias  <= 8'sd0;
            acc   <= 24'sd0;
            ptr   <= 3'd0;
            out_q <= 8'h00;
            sat_q <= 1'b0;
        end else if (strobe) begin
            case (op)
                OP_LOAD_W:   w[arg] <= ui_in;
                OP_LOAD_B:   bias   <= ui_in;
                OP_CLEAR: begin
                    acc <= {{16{bias[7]}}, bias};
                    ptr <= 3'd0;
                end
                OP_MAC: begin
                    acc <= acc + {{8{prod[15]}}, prod};
                    ptr <= ptr + 3'd1;
                end
                OP_FIRE: begin
                    out_q <= fire_out;
                    sat_q <= fire_sat;
                end
                OP_READ_ACC: out_q <= acc_byte;
                default: ;
            endcase
        end
    end

    assign uo_out  = out_q;
    assign uio_out = {sat_q, 7'b0};
    assign uio_oe  = 8'h80;

endmodule

// File: tb/tb_tt_um_snpu.sv
// Bench for tt_um_snpu: integer reference model checked every cycle plus literal spot checks.
module tb_tt_um_snpu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    tt_um_snpu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

`ifdef SNPU_RELU_EN
    localparam logic [7:0] NEG_OUT    = 8'h00;
    localparam logic [7:0] BIG_OUT    = 8'hFF;
    localparam logic [7:0] NSAT_OUT   = 8'h00;
    localparam logic [7:0] NSAT_FLAG  = 8'h00;
    localparam logic [7:0] NSH7_OUT   = 8'h00;
`else
    localparam logic [7:0] NEG_OUT    = 8'h9C;
    localparam logic [7:0] BIG_OUT    = 8'h7F;
    localparam logic [7:0] NSAT_OUT   = 8'h80;
    localparam logic [7:0] NSAT_FLAG  = 8'h80;
    localparam logic [7:0] NSH7_OUT   = 8'h81;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    // Reference state as plain integers.
    int mw [8];
    int mb, macc, mptr, mout;
    bit msat;

    function automatic int wrap24(int x);
        int r = x & 32'h00FF_FFFF;
        if (r >= 32'h0080_0000) r -= 32'h0100_0000;
        return r;
    endfunction

    function automatic int s8(int x);
        int r = x & 255;
        if (r >= 128) r -= 256;
        return r;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%02h, want 0x%02h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mw[i] = 0;
        mb = 0; macc = 0; mptr = 0; mout = 0; msat = 0;
    endtask

    task automatic model_step(int op, int arg, int d);
        int v, sel;
        case (op)
            1: mw[arg] = s8(d);
            2: mb = s8(d);
            3: begin macc = mb; mptr = 0; end
            4: begin
                macc = wrap24(macc + s8(d) * mw[mptr]);
                mptr = (mptr + 1) % 8;
            end
            5: begin
                v = macc >>> arg;
`ifdef SNPU_RELU_EN
                if (v < 0)        begin mout = 0;   msat = 0; end
                else if (v > 255) begin mout = 255; msat = 1; end
                else              begin mout = v;   msat = 0; end
`else
                if (v < -128)     begin mout = 128; msat = 1; end
                else if (v > 127) begin mout = 127; msat = 1; end
                else              begin mout = v & 255; msat = 0; end
`endif
            end
            6: begin
                sel = arg & 3;
                mout = (sel == 3) ? 0 : (((macc & 32'h00FF_FFFF) >> (8 * sel)) & 255);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("uo_out", uo_out, 8'(mout));
            check("uio_out", uio_out, {msat, 7'b0});
            check("uio_oe", uio_oe, 8'h80);
        end
    end

    task automatic cmd(bit stb, int op, int arg, int d);
        @(negedge clk);
        #2;
        ui_in  = 8'(d);
        uio_in = {1'($urandom), 3'(arg), stb, 3'(op)};
        @(posedge clk);
        if (stb && rst_n == 1'b0) model_step(op, arg, d);
    endtask

    task automatic op_(int op, int arg, int d);
        cmd(1'b1, op, arg, d);
    endtask

    task automatic idle();
        cmd(1'b0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
    endtask

    task automatic lit(string name, logic [7:0] exp_uo, logic [7:0] exp_uio);
        #1;
        check({name, "_uo"}, uo_out, exp_uo);
        check({name, "_uio"}, uio_out, exp_uio);
    endtask

    task automatic rst_pulse(int n);
        @(negedge clk);
        #2;
        uio_in = 8'h0C;
        ui_in  = 8'h55;
        rst_n  = 1'b1;
        model_clear();
        repeat (n) @(posedge clk);
        #1;
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'h80);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        uio_in = 8'h00;
    endtask

    initial begin
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_clear();
        #1;
        rst_pulse(2);
        chk_on = 1;
        op_(5, 0, 0);          lit("fire_after_rst", 8'h00, 8'h00);

        // dot product: 5 + 10*2 + 4*(-3) = 13
        op_(1, 0, 2); op_(1, 1, 8'hFD); op_(2, 0, 5); op_(3, 0, 0);
        op_(4, 0, 10); idle(); op_(4, 0, 4);
        op_(6, 0, 0);          lit("dot_acc", 8'h0D, 8'h00);
        op_(5, 0, 0);          lit("dot_fire", 8'h0D, 8'h00);

        // negative: -1 * 100
        op_(1, 0, 8'hFF); op_(2, 0, 0); op_(3, 0, 0); op_(4, 0, 100);
        op_(6, 2, 0);          lit("neg_b2", 8'hFF, 8'h00);
        op_(6, 0, 0);          lit("neg_b0", 8'h9C, 8'h00);
        op_(5, 0, 0);          lit("neg_fire", NEG_OUT, 8'h00);

        // 127*127 = 16129 = 0x003F01; >>>4 = 1008
        op_(1, 0, 127); op_(3, 0, 0); op_(4, 0, 127);
        op_(6, 0, 0);          lit("big_b0", 8'h01, 8'h00);
        op_(6, 1, 0);          lit("big_b1", 8'h3F, 8'h00);
        op_(6, 2, 0);          lit("big_b2", 8'h00, 8'h00);
        op_(6, 3, 0);          lit("big_b3", 8'h00, 8'h00);
        op_(5, 4, 0);          lit("big_fire", BIG_OUT, 8'h80);
        op_(6, 0, 0);          lit("read_keeps_sat", 8'h01, 8'h80);
        op_(7, 0, 0);          lit("rsvd_nop", 8'h01, 8'h80);

        // -128*127 = -16256; >>>7 = -127
        op_(1, 0, 8'h80); op_(3, 0, 0); op_(4, 0, 127);
        op_(5, 0, 0);          lit("nsat_fire", NSAT_OUT, NSAT_FLAG);
        op_(5, 7, 0);          lit("nsh7_fire", NSH7_OUT, 8'h00);

        // pointer wrap: nine MACs of 1 then MAC 5 via w[1]
        for (int i = 0; i < 8; i++) begin
            op_(1, i, 1);
            idle();
        end
        op_(3, 0, 0);
        repeat (9) begin
            op_(4, 0, 1);
            idle();
        end
        op_(6, 0, 0);          lit("wrap_acc9", 8'h09, 8'h00);
        op_(4, 0, 5);
        op_(6, 0, 0);          lit("wrap_acc14", 8'h0E, 8'h00);

        // reset in the middle of an accumulation
        op_(1, 0, 3); op_(2, 0, 7); op_(3, 0, 0); op_(4, 0, 2); op_(4, 0, 2);
        rst_pulse(1);
        op_(3, 0, 0);
        op_(5, 0, 0);          lit("midrst_fire", 8'h00, 8'h00);
        op_(6, 0, 0);          lit("midrst_acc", 8'h00, 8'h00);

        // random traffic against the model
        repeat (400) begin
            cmd(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 255));
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
